// File: rtl/pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_stretcher: stretches single-cycle pulses into programmable-length    |
// | high windows, with a minimum low gap and queued or retriggered pulses.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pulse_stretcher #(
  parameter int CNT_W  = 8,
  parameter int GAP    = 1,
  parameter int PEND_W = 4,
  parameter int RETRIG = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pulse,
  input  logic              i_clear,
  input  logic [CNT_W-1:0]  i_len,
  output logic              o_level,
  output logic              o_busy,
  output logic              o_done,
  output logic [PEND_W-1:0] o_pend,
  output logic              o_ovf
);

  localparam int                     c_gcnt_w   = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [c_gcnt_w-1:0]    c_gap_load = c_gcnt_w'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [PEND_W-1:0]      c_pend_max = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [c_gcnt_w-1:0] r_gcnt, w_gcnt_nx;
  logic [PEND_W-1:0]   r_pend, w_pend_nx;
  logic                r_ovf, w_ovf_nx;
  logic                r_done, w_done_nx;
  logic [CNT_W-1:0]    w_len_m1;
  logic                w_req;
  logic                w_start;
  logic                w_take;
  logic                w_add;

  // A zero length is treated as a one-cycle window.
  assign w_len_m1 = (i_len == '0) ? '0 : i_len - CNT_W'(1);
  assign w_req    = (r_pend != '0) || i_pulse;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_gcnt_nx  = r_gcnt;
    w_pend_nx  = r_pend;
    w_ovf_nx   = r_ovf;
    w_done_nx  = 1'b0;
    w_start    = 1'b0;
    w_take     = 1'b0;
    w_add      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) w_start = 1'b1;
      end
      S_ACTIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
          if (i_pulse) begin
            if (RETRIG != 0) w_cnt_nx = w_len_m1;
            else             w_add    = 1'b1;
          end
        end else begin
          w_done_nx = 1'b1;
          if (GAP > 0) begin
            w_state_nx = S_GAP;
            w_gcnt_nx  = c_gap_load;
            w_add      = i_pulse;
          end else if (w_req) begin
            w_start = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gcnt != '0) begin
          w_gcnt_nx = r_gcnt - c_gcnt_w'(1);
          w_add     = i_pulse;
        end else if (w_req) begin
          w_start = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Queued pulses take precedence; a fresh pulse is used directly only when the queue is empty.
    if (w_start) begin
      w_state_nx = S_ACTIVE;
      w_cnt_nx   = w_len_m1;
      w_take     = (r_pend != '0);
      w_add      = i_pulse && (r_pend != '0);
    end

    case ({w_take, w_add})
      2'b10: w_pend_nx = r_pend - PEND_W'(1);
      2'b01: begin
        if (r_pend == c_pend_max) w_ovf_nx  = 1'b1;
        else                      w_pend_nx = r_pend + PEND_W'(1);
      end
      default: w_pend_nx = r_pend;
    endcase

    if (i_clear) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_gcnt_nx  = '0;
      w_pend_nx  = '0;
      w_ovf_nx   = 1'b0;
      w_done_nx  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_gcnt  <= w_gcnt_nx;
      r_pend  <= w_pend_nx;
      r_ovf   <= w_ovf_nx;
      r_done  <= w_done_nx;
    end
  end

  assign o_level = (r_state == S_ACTIVE);
  assign o_busy  = (r_state != S_IDLE) || (r_pend != '0);
  assign o_done  = r_done;
  assign o_pend  = r_pend;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// Bench for pulse_stretcher: four parameter variants share one stimulus stream and
// are checked every cycle against a remaining-cycles model, plus literal expectations.
module tb_pulse_stretcher;

  localparam int P_GAP [4] = '{1, 1, 1, 0};
  localparam int P_PW  [4] = '{4, 2, 4, 4};
  localparam int P_RT  [4] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] len = 8'd1;
  bit         chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic       d_lvl [4];
  logic       d_busy[4];
  logic       d_done[4];
  logic       d_ovf [4];
  logic [7:0] d_pend[4];
  logic [3:0] p0, p2, p3;
  logic [1:0] p1;

  assign d_pend[0] = 8'(p0);
  assign d_pend[1] = 8'(p1);
  assign d_pend[2] = 8'(p2);
  assign d_pend[3] = 8'(p3);

  always #5 clk = ~clk;

  pulse_stretcher #(.CNT_W(8), .GAP(1), .PEND_W(4), .RETRIG(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_clear(clear), .i_len(len),
    .o_level(d_lvl[0]), .o_busy(d_busy[0]), .o_done(d_done[0]), .o_pend(p0), .o_ovf(d_ovf[0]));
  pulse_stretcher #(.CNT_W(8), .GAP(1), .PEND_W(2), .RETRIG(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_clear(clear), .i_len(len),
    .o_level(d_lvl[1]), .o_busy(d_busy[1]), .o_done(d_done[1]), .o_pend(p1), .o_ovf(d_ovf[1]));
  pulse_stretcher #(.CNT_W(8), .GAP(1), .PEND_W(4), .RETRIG(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_clear(clear), .i_len(len),
    .o_level(d_lvl[2]), .o_busy(d_busy[2]), .o_done(d_done[2]), .o_pend(p2), .o_ovf(d_ovf[2]));
  pulse_stretcher #(.CNT_W(8), .GAP(0), .PEND_W(4), .RETRIG(0)) u_d (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_clear(clear), .i_len(len),
    .o_level(d_lvl[3]), .o_busy(d_busy[3]), .o_done(d_done[3]), .o_pend(p3), .o_ovf(d_ovf[3]));

  // Model: m_hi = high cycles still to come (including the current one), m_gap = low gap cycles left.
  int m_hi  [4] = '{0, 0, 0, 0};
  int m_gap [4] = '{0, 0, 0, 0};
  int m_pend[4] = '{0, 0, 0, 0};
  bit m_ovf [4] = '{0, 0, 0, 0};
  bit m_done[4] = '{0, 0, 0, 0};

  task automatic enqueue(input int i);
    if (m_pend[i] == (1 << P_PW[i]) - 1) m_ovf[i] = 1'b1;
    else                                 m_pend[i]++;
  endtask

  task automatic try_start(input int i, input bit p, input int wlen);
    if (m_pend[i] > 0) begin
      m_pend[i]--;
      m_hi[i] = wlen;
      if (p) enqueue(i);
    end else if (p) begin
      m_hi[i] = wlen;
    end else begin
      m_hi[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit p, input bit clr, input bit r, input int l);
    int wlen;
    wlen = (l == 0) ? 1 : l;
    if (r || clr) begin
      m_hi[i] = 0; m_gap[i] = 0; m_pend[i] = 0; m_ovf[i] = 1'b0; m_done[i] = 1'b0;
    end else begin
      m_done[i] = (m_hi[i] == 1);
      if (m_hi[i] > 1) begin
        if (p && P_RT[i] != 0) m_hi[i] = wlen;
        else begin
          if (p) enqueue(i);
          m_hi[i]--;
        end
      end else if (m_hi[i] == 1) begin
        m_hi[i] = 0;
        if (P_GAP[i] > 0) begin
          m_gap[i] = P_GAP[i];
          if (p) enqueue(i);
        end else begin
          try_start(i, p, wlen);
        end
      end else if (m_gap[i] > 1) begin
        m_gap[i]--;
        if (p) enqueue(i);
      end else begin
        m_gap[i] = 0;
        try_start(i, p, wlen);
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) model_step(i, pulse, clear, rst, int'(len));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        logic       e_lvl, e_busy;
        logic [7:0] e_pend;
        e_lvl  = (m_hi[i] > 0);
        e_busy = (m_hi[i] > 0) || (m_gap[i] > 0) || (m_pend[i] > 0);
        e_pend = 8'(m_pend[i]);
        n_tests++;
        if (d_lvl[i] !== e_lvl || d_busy[i] !== e_busy || d_done[i] !== m_done[i] ||
            d_pend[i] !== e_pend || d_ovf[i] !== m_ovf[i]) begin
          n_fail++;
          $display("FAIL model[%0d] t=%0t: got lvl=%b busy=%b done=%b pend=%0d ovf=%b expected lvl=%b busy=%b done=%b pend=%0d ovf=%b",
                   i, $time, d_lvl[i], d_busy[i], d_done[i], d_pend[i], d_ovf[i],
                   e_lvl, e_busy, m_done[i], e_pend, m_ovf[i]);
        end
      end
    end
  end

  // Per-cycle log of DUT outputs of the latest scenario, index = cycle number.
  logic [31:0] lg_lvl [4];
  logic [31:0] lg_busy[4];
  logic [31:0] lg_done[4];
  logic [31:0] lg_ovf [4];
  logic [7:0]  lg_pend[4][32];

  task automatic log_cycle(input int c);
    for (int i = 0; i < 4; i++) begin
      lg_lvl[i][c]  = d_lvl[i];
      lg_busy[i][c] = d_busy[i];
      lg_done[i][c] = d_done[i];
      lg_ovf[i][c]  = d_ovf[i];
      lg_pend[i][c] = d_pend[i];
    end
  endtask

  task automatic play(input int l, input logic [31:0] pm, input logic [31:0] cm,
                      input logic [31:0] rm, input int n);
    len = 8'(l); pulse = 1'b0; clear = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_cycle(0);
    for (int k = 0; k < n; k++) begin
      pulse = pm[k]; clear = cm[k]; rst = rm[k];
      @(posedge clk); #1;
      log_cycle(k + 1);
    end
    pulse = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Basic window, GAP=1
    play(3, 32'h0000_0400, 32'h0, 32'h0, 24);
    chk("reset_lvl", int'(lg_lvl[0][0]), 0);
    chk("reset_busy", int'(lg_busy[0][0]), 0);
    chk("reset_pend", int'(lg_pend[0][0]), 0);
    chk("basic_lvl10", int'(lg_lvl[0][10]), 0);
    chk("basic_lvl11", int'(lg_lvl[0][11]), 1);
    chk("basic_lvl13", int'(lg_lvl[0][13]), 1);
    chk("basic_lvl14", int'(lg_lvl[0][14]), 0);
    chk("basic_done13", int'(lg_done[0][13]), 0);
    chk("basic_done14", int'(lg_done[0][14]), 1);
    chk("basic_busy14", int'(lg_busy[0][14]), 1);
    chk("basic_busy15", int'(lg_busy[0][15]), 0);

    // Queued pulse
    play(2, 32'h0000_0C00, 32'h0, 32'h0, 24);
    chk("queue_lvl13", int'(lg_lvl[0][13]), 0);
    chk("queue_lvl14", int'(lg_lvl[0][14]), 1);
    chk("queue_lvl15", int'(lg_lvl[0][15]), 1);
    chk("queue_lvl16", int'(lg_lvl[0][16]), 0);
    chk("queue_done13", int'(lg_done[0][13]), 1);
    chk("queue_done16", int'(lg_done[0][16]), 1);
    chk("queue_pend12", int'(lg_pend[0][12]), 1);
    chk("queue_pend13", int'(lg_pend[0][13]), 1);
    chk("queue_pend14", int'(lg_pend[0][14]), 0);

    // Overflow on the PEND_W=2 instance, then clear
    play(8, 32'h0000_7C00, 32'h0010_0000, 32'h0, 24);
    chk("ovf_pend14", int'(lg_pend[1][14]), 3);
    chk("ovf_ovf14", int'(lg_ovf[1][14]), 0);
    chk("ovf_ovf15", int'(lg_ovf[1][15]), 1);
    chk("ovf_ovf20", int'(lg_ovf[1][20]), 1);
    chk("ovf_lvl20", int'(lg_lvl[1][20]), 1);
    chk("clr_ovf21", int'(lg_ovf[1][21]), 0);
    chk("clr_pend21", int'(lg_pend[1][21]), 0);
    chk("clr_lvl21", int'(lg_lvl[1][21]), 0);
    chk("clr_done21", int'(lg_done[1][21]), 0);

    // Retrigger instance
    play(4, 32'h0000_1400, 32'h0, 32'h0, 24);
    for (int c = 11; c <= 16; c++) chk($sformatf("retrig_lvl%0d", c), int'(lg_lvl[2][c]), 1);
    for (int c = 11; c <= 16; c++) chk($sformatf("retrig_done%0d", c), int'(lg_done[2][c]), 0);
    chk("retrig_lvl17", int'(lg_lvl[2][17]), 0);
    chk("retrig_done17", int'(lg_done[2][17]), 1);
    chk("retrig_pend13", int'(lg_pend[2][13]), 0);

    // Zero length, back-to-back on the GAP=0 instance
    play(0, 32'h0000_0C00, 32'h0, 32'h0, 24);
    chk("zl_lvl11", int'(lg_lvl[3][11]), 1);
    chk("zl_lvl12", int'(lg_lvl[3][12]), 1);
    chk("zl_lvl13", int'(lg_lvl[3][13]), 0);
    chk("zl_done12", int'(lg_done[3][12]), 1);
    chk("zl_done13", int'(lg_done[3][13]), 1);

    // Reset mid-window
    play(5, 32'h0000_2400, 32'h0, 32'h0000_1000, 24);
    chk("rst_lvl12", int'(lg_lvl[0][12]), 1);
    chk("rst_lvl13", int'(lg_lvl[0][13]), 0);
    chk("rst_busy13", int'(lg_busy[0][13]), 0);
    chk("rst_done13", int'(lg_done[0][13]), 0);
    chk("rst_lvl14", int'(lg_lvl[0][14]), 1);
    chk("rst_lvl18", int'(lg_lvl[0][18]), 1);
    chk("rst_lvl19", int'(lg_lvl[0][19]), 0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts single-cycle event pulses back into level windows of programmable length. Each accepted pulse drives a high window of i_len cycles on o_level, with a configurable minimum low gap between consecutive windows. Pulses that arrive while a window or gap is in progress are queued in a saturating counter, or restart the active window, depending on a parameter. It is the consumer of edge-detected single-cycle pulses in the datapath control logic.

Parameters:
CNT_W, 8, width of i_len and of the window counter
GAP, 1, minimum number of forced-low cycles between consecutive windows; 0 is legal
PEND_W, 4, width of the pending-pulse counter
RETRIG, 0, selects handling of pulses during ACTIVE: 0 = queue; 1 = restart the current window

Ports:
i_clk  input  1  clock; all logic is on the rising edge
i_rst  input  1  synchronous reset, active-high
i_pulse  input  1  event; every cycle it is high counts as one pulse
i_clear  input  1  synchronous abort/flush
i_len  input  CNT_W  window length, sampled when a window starts or restarts; 0 is treated as 1
o_level  output  1  stretched level
o_busy  output  1  high when state != IDLE or pend != 0
o_done  output  1  one-cycle strobe in the first cycle after each window's last high cycle
o_pend  output  PEND_W  number of queued pulses
o_ovf  output  1  sticky flag; set when a pulse is dropped because pend is saturated

Behaviour:
- All outputs are registered or decoded from registered state. Reset value of every output is 0. Reset state is IDLE with cnt = gcnt = pend = 0.
- Priority each cycle: i_rst > i_clear > normal operation.
- States:
  - IDLE: o_level = 0.
  - ACTIVE: o_level = 1.
  - GAP: o_level = 0.
- Start rule: let L = max(i_len, 1), sampled at the start cycle. On start, the next cycle has state = ACTIVE and cnt = L-1.
- Latency: a pulse in IDLE at cycle t gives o_level = 1 for cycles t+1 .. t+L.
- ACTIVE, cnt != 0:
  - cnt decrements.
  - RETRIG=1 and i_pulse: reload cnt = L-1 instead. The level stays high with no glitch and pend is unchanged.
  - RETRIG=0 and i_pulse: pend increments.
- ACTIVE, cnt == 0 (last high cycle):
  - o_done = 1 in the next cycle.
  - GAP > 0: go to GAP with gcnt = GAP-1.
  - GAP == 0: if pend > 0 or i_pulse, start a new window (o_level stays high continuously). Otherwise go to IDLE.
- GAP:
  - A pulse is always queued, regardless of RETRIG.
  - gcnt decrements.
  - At gcnt == 0: if pend > 0 or i_pulse, start a new window. Otherwise go to IDLE.
- Pend accounting:
  - A start from the queue consumes 1.
  - A simultaneous i_pulse adds 1, so the net is unchanged.
  - pend saturates at 2^PEND_W - 1. A pulse at saturation that is not consumed in the same cycle is dropped, and o_ovf = 1 from the next cycle.
- i_clear:
  - Next cycle: state = IDLE, cnt = gcnt = pend = 0, o_ovf = 0, o_level = 0.
  - No o_done is generated by the abort.
  - An i_pulse in the same cycle as i_clear is dropped.
- i_rst mid-operation: same effect as i_clear.
- Counter widths: cnt has CNT_W bits and never wraps, because it is only decremented at nonzero. gcnt is sized $clog2(GAP+1) with a minimum of 1 bit.

Test Plan:
- Basic window: len=3, GAP=1, pulse at cycle 10 -> o_level high 11–13; o_done at 14; o_busy 11–14; IDLE at 15.
- Queued pulse: len=2, GAP=1, pulses at 10 and 11:
  - o_level high 11–12, low 13, high 14–15.
  - o_done at 13 and 16.
  - o_pend = 1 during 12–13, 0 from 14.
- Overflow: PEND_W=2, len=8, pulses every cycle 10–14:
  - o_pend reaches 3 at cycle 14.
  - Pulse at 14 is dropped; o_ovf = 1 from 15 and remains set.
  - i_clear at 20 -> o_ovf = 0, o_pend = 0, o_level = 0 at 21; no o_done.
- Retrigger: RETRIG=1, len=4, pulses at 10 and 12 -> o_level high 11–16 continuously; single o_done at 17; o_pend stays 0.
- Zero length and back-to-back: i_len=0, GAP=0, pulses at 10 and 11:
  - o_level high 11–12 with no low cycle between windows.
  - o_done at 12 and 13.
- Reset mid-window: len=5, pulse at 10, i_rst at 12 -> all outputs 0 at 13; a pulse at 13 starts a fresh window at 14.
